// File: rtl/ets_sweep_ctrl_if.sv
// Sweep controller side-band bus: MMCM dynamic phase-shift port plus the
// valid/ready write port into the sample buffer.
interface ets_sweep_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  ps_en;
  logic                  ps_incdec;
  logic                  ps_done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output ps_en, ps_incdec, wr_valid, wr_addr, wr_data,
    input  ps_done, wr_ready
  );

  modport slave (
    input  ps_en, ps_incdec, wr_valid, wr_addr, wr_data,
    output ps_done, wr_ready
  );
endinterface

// File: rtl/ets_sweep_ctrl.sv
// Equivalent-time-sampling sweep sequencer: steps the MMCM phase, waits for
// the shift to complete, settles, accumulates comparator hits over a number
// of triggers and writes one result word per phase step.
//
// state     | meaning
// IDLE      | waiting for start && en
// SHIFT     | one-cycle ps_en pulse
// WAIT_DONE | waiting for ps_done (bounded by PS_TIMEOUT)
// SETTLE    | SETTLE_CYC idle cycles after the shift
// ACQ       | accumulate cmp_data on each trig until avg triggers seen
// WRITE     | present result until wr_ready
// NEXT      | advance step or finish
// DONE      | one-cycle done pulse
module ets_sweep_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int PHASE_PERIOD = 1120,
  parameter int SETTLE_CYC   = 16,
  parameter int PS_TIMEOUT   = 1024
) (
  input  logic                shifting_clk,
  input  logic                S_AXI_DATA_aresetn,
  input  logic                start,
  input  logic                en,
  input  logic [15:0]         cfg_avg,
  input  logic [ADDR_WIDTH:0] cfg_steps,
  input  logic                trig,
  input  logic                cmp_data,
  ets_sweep_ctrl_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         phase_counter
);
  // one shared down-counter serves both the PS timeout and the settle delay
  localparam int TMAX = (PS_TIMEOUT > SETTLE_CYC) ? PS_TIMEOUT : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [ADDR_WIDTH:0] STEP_ONE  = 1;
  localparam logic [TW-1:0]       TIMER_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, SHIFT, WAIT_DONE, SETTLE, ACQ, WRITE, NEXT, DONE
  } state_t;

  state_t              state_q, state_nxt;
  logic [TW-1:0]       timer_q;
  logic [15:0]         avg_q;
  logic [15:0]         acc_q;
  logic [15:0]         tcnt_q;
  logic [ADDR_WIDTH:0] steps_q;
  logic [ADDR_WIDTH:0] step_q;
  logic                last_step;
  logic                last_trig;
  logic                timer_tc;

  assign last_step = (step_q == steps_q - STEP_ONE);
  assign last_trig = (({1'b0, tcnt_q} + 17'd1) == {1'b0, avg_q});
  assign timer_tc  = (timer_q == '0);

  assign busy          = (state_q != IDLE);
  assign bus.ps_incdec = 1'b1;
  assign bus.wr_addr   = step_q[ADDR_WIDTH-1:0];
  assign bus.wr_data   = DATA_WIDTH'(acc_q);

  // state register
  always_ff @(posedge shifting_clk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) state_q <= IDLE;
    else                     state_q <= state_nxt;
  end

  // next-state and strobe outputs
  always_comb begin
    state_nxt    = state_q;
    bus.ps_en    = 1'b0;
    bus.wr_valid = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && en) state_nxt = (cfg_steps == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        bus.ps_en = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // en is deliberately ignored until the MMCM handshake finishes
        if (bus.ps_done)   state_nxt = en ? SETTLE : IDLE;
        else if (timer_tc) state_nxt = IDLE;
      end
      SETTLE: begin
        if (!en)           state_nxt = IDLE;
        else if (timer_tc) state_nxt = ACQ;
      end
      ACQ: begin
        if (!en)                    state_nxt = IDLE;
        else if (trig && last_trig) state_nxt = WRITE;
      end
      WRITE: begin
        bus.wr_valid = 1'b1;
        if (!en)               state_nxt = IDLE;
        else if (bus.wr_ready) state_nxt = NEXT;
      end
      NEXT: begin
        state_nxt = last_step ? DONE : SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sweep datapath: config latch, timer, accumulator, step index, phase
  always_ff @(posedge shifting_clk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      timer_q       <= '0;
      avg_q         <= '0;
      acc_q         <= '0;
      tcnt_q        <= '0;
      steps_q       <= '0;
      step_q        <= '0;
      err           <= 1'b0;
      phase_counter <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && en) begin
            avg_q   <= (cfg_avg == 16'd0) ? 16'd1 : cfg_avg;
            steps_q <= cfg_steps;
            step_q  <= '0;
            err     <= 1'b0;
          end
        end
        SHIFT: timer_q <= TW'(PS_TIMEOUT - 1);
        WAIT_DONE: begin
          if (bus.ps_done) begin
            phase_counter <= (phase_counter == 32'(PHASE_PERIOD - 1)) ?
                             32'd0 : phase_counter + 32'd1;
            timer_q       <= TW'(SETTLE_CYC - 1);
          end else if (timer_tc) begin
            err <= 1'b1;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end
        SETTLE: begin
          if (!timer_tc) begin
            timer_q <= timer_q - TIMER_ONE;
          end else begin
            acc_q  <= '0;
            tcnt_q <= '0;
          end
        end
        ACQ: begin
          if (trig) begin
            acc_q  <= acc_q + {15'd0, cmp_data};
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        NEXT: if (!last_step) step_q <= step_q + STEP_ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Scoreboard bench for ets_sweep_ctrl: an MMCM/trigger responder model pushes
// the expected result of each phase step, a monitor pops and compares on
// every accepted write, and the stimulus process checks sweep-level totals.
module tb_ets_sweep_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int PP = 4;
  localparam int SC = 4;
  localparam int TO = 64;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic          shifting_clk = 0;
  logic          S_AXI_DATA_aresetn;
  logic          start, en, trig, cmp_data;
  logic [15:0]   cfg_avg;
  logic [AW:0]   cfg_steps;
  logic          busy, done, err;
  logic [31:0]   phase_counter;

  ets_sweep_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ets_sweep_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_PERIOD(PP),
    .SETTLE_CYC(SC), .PS_TIMEOUT(TO)
  ) dut (
    .shifting_clk(shifting_clk), .S_AXI_DATA_aresetn(S_AXI_DATA_aresetn),
    .start(start), .en(en), .cfg_avg(cfg_avg), .cfg_steps(cfg_steps),
    .trig(trig), .cmp_data(cmp_data), .bus(bus),
    .busy(busy), .done(done), .err(err), .phase_counter(phase_counter)
  );

  always #5 shifting_clk = ~shifting_clk;

  int  tests = 0, fails = 0;
  wr_t exp_q[$];
  int  ps_en_cnt = 0, done_cnt = 0, wr_cnt = 0, stall_cnt = 0;
  int  total_done = 0, push_cnt = 0, inject_req = 0;
  int  done_base = 0, sweep_base = 0;
  int  k_lo = 5, k_hi = 5, resp_avg = 1, resp_mode = 0, hold_len = 0;
  bit  withhold = 0, ready_rand = 0, resp_busy = 0, in_acq = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // MMCM + trigger source model; pushes the expected word for each full step
  initial begin : responder
    int k, n, sum, c, inj_seen;
    bit ab;
    wr_t e;
    inj_seen = 0;
    bus.ps_done = 0; trig = 0; cmp_data = 0;
    forever begin
      @(negedge shifting_clk);
      if (inject_req != inj_seen) begin
        inj_seen = inject_req;
        bus.ps_done = 1;
        @(negedge shifting_clk);
        bus.ps_done = 0;
      end else if (bus.ps_en && !withhold && S_AXI_DATA_aresetn) begin
        resp_busy = 1; ab = 0;
        k = $urandom_range(k_hi, k_lo);
        repeat (k) @(negedge shifting_clk);
        bus.ps_done = 1; total_done++;
        @(negedge shifting_clk);
        bus.ps_done = 0;
        if (!en) ab = 1;
        for (int i = 0; i < SC - 1; i++) begin
          @(negedge shifting_clk);
          if (!en) ab = 1;
        end
        // trigger on the last settle cycle must be ignored
        if (!ab) begin trig = 1; cmp_data = 1; end
        @(negedge shifting_clk);
        trig = 0;
        n = 0; sum = 0; in_acq = 1;
        while (!ab && n < resp_avg) begin
          if (!en) ab = 1;
          else begin
            trig = (n == 0) || ($urandom_range(0, 2) != 0);
            case (resp_mode)
              1:       c = 1;
              2:       c = (n % 2 == 0) ? 1 : 0;
              default: c = $urandom_range(0, 1);
            endcase
            cmp_data = trig ? c[0] : ($urandom_range(0, 1) == 1);
            if (trig) begin
              sum += c; n++;
              if (n == resp_avg) begin
                e.addr = AW'(push_cnt - sweep_base);
                e.data = DW'(sum);
                exp_q.push_back(e);
                push_cnt++;
              end
            end
            @(negedge shifting_clk);
          end
        end
        trig = 0; in_acq = 0; resp_busy = 0;
      end
    end
  end

  // buffer-side ready: optional hold-off per write, else random or always ready
  initial begin : ready_drv
    int held;
    held = 0;
    bus.wr_ready = 0;
    forever begin
      @(posedge shifting_clk); #1;
      if (!bus.wr_valid) held = 0;
      if (bus.wr_valid && held < hold_len) begin
        bus.wr_ready = 0; held++;
      end else begin
        bus.wr_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // monitor: scoreboard pops, write-port stability, event counting
  initial begin : monitor
    bit prev_stall;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wr_t e;
    prev_stall = 0; pa = '0; pd = '0;
    forever begin
      @(negedge shifting_clk);
      if (!S_AXI_DATA_aresetn) prev_stall = 0;
      else begin
        if (prev_stall) begin
          chk("wr_valid_held", bus.wr_valid, 1);
          chk("wr_addr_stable", bus.wr_addr, pa);
          chk("wr_data_stable", bus.wr_data, pd);
        end
        if (bus.ps_en) begin
          ps_en_cnt++;
          chk("ps_en_no_pending_write", exp_q.size(), 0);
        end
        if (done) done_cnt++;
        if (bus.wr_valid && bus.wr_ready) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: addr %0d data %0d with no expected entry", bus.wr_addr, bus.wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.wr_addr, e.addr);
            chk("wr_data", bus.wr_data, e.data);
          end
        end
        prev_stall = bus.wr_valid && !bus.wr_ready;
        if (bus.wr_valid && !bus.wr_ready) stall_cnt++;
        pa = bus.wr_addr; pd = bus.wr_data;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || resp_busy) && n < 20000) begin @(negedge shifting_clk); n++; end
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL %s: still busy after %0d cycles", nm, n);
    end
  endtask

  task automatic pulse_start();
    start = 1; @(negedge shifting_clk); start = 0;
  endtask

  task automatic run_sweep(input int steps, input int avg, input int mode, input bit poke);
    int d0, p0, w0, n;
    cfg_steps = AW'(0) + (AW+1)'(steps); cfg_avg = 16'(avg);
    resp_avg = (avg == 0) ? 1 : avg; resp_mode = mode; sweep_base = push_cnt;
    d0 = done_cnt; p0 = ps_en_cnt; w0 = wr_cnt;
    pulse_start();
    chk("err_cleared_on_start", err, 0);
    if (steps == 0) chk("zero_steps_done_next_cycle", done, 1);
    if (poke) begin
      n = 0;
      while (!in_acq && n < 500) begin @(negedge shifting_clk); n++; end
      cfg_steps = 7; cfg_avg = 3;
      pulse_start();
    end
    wait_idle("sweep_idle");
    chk("sweep_done_pulses", done_cnt - d0, 1);
    chk("sweep_ps_en_pulses", ps_en_cnt - p0, steps);
    chk("sweep_writes", wr_cnt - w0, steps);
    chk("sweep_phase", phase_counter, (total_done - done_base) % PP);
    chk("sweep_err", err, 0);
    chk("sweep_queue_drained", exp_q.size(), 0);
  endtask

  initial begin : stim
    int d0, p0, w0, s0, n, cyc;
    S_AXI_DATA_aresetn = 0; start = 0; en = 1; cfg_avg = 0; cfg_steps = 0;
    repeat (3) @(negedge shifting_clk);
    chk("rst_ps_en", bus.ps_en, 0);
    chk("rst_ps_incdec", bus.ps_incdec, 1);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_phase", phase_counter, 0);
    S_AXI_DATA_aresetn = 1; done_base = total_done;
    @(negedge shifting_clk);

    // basic sweep, all hits, with a start pulse issued while busy
    k_lo = 5; k_hi = 5;
    run_sweep(4, 8, 1, 1);
    // alternating hits, then avg=0 behaving as one trigger
    k_lo = 1; k_hi = 8;
    run_sweep(3, 10, 2, 0);
    run_sweep(2, 0, 0, 0);

    // buffer stalls for 20 cycles on a single write
    hold_len = 20; s0 = stall_cnt;
    run_sweep(1, 4, 1, 0);
    chk("stall_cycles", stall_cnt - s0, 20);
    hold_len = 0;

    // ps_done withheld: timeout after PS_TIMEOUT cycles in WAIT_DONE
    withhold = 1; cfg_steps = 2; cfg_avg = 1; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!bus.ps_en && n < 10) begin @(negedge shifting_clk); n++; end
    cyc = 0;
    while (busy && cyc < 4 * TO) begin @(negedge shifting_clk); cyc++; end
    chk("timeout_cycles", cyc, TO + 1);
    chk("timeout_err", err, 1);
    chk("timeout_no_done", done_cnt - d0, 0);
    withhold = 0;
    run_sweep(1, 3, 0, 0);

    // en dropped during acquisition
    cfg_steps = 2; cfg_avg = 50; resp_avg = 50; resp_mode = 0;
    sweep_base = push_cnt; d0 = done_cnt; p0 = ps_en_cnt; w0 = wr_cnt;
    pulse_start();
    n = 0;
    while (!in_acq && n < 500) begin @(negedge shifting_clk); n++; end
    repeat (3) @(negedge shifting_clk);
    en = 0;
    @(negedge shifting_clk);
    chk("abort_acq_idle_next_cycle", busy, 0);
    wait_idle("abort_acq");
    en = 1;
    chk("abort_acq_no_write", wr_cnt - w0, 0);
    chk("abort_acq_no_done", done_cnt - d0, 0);
    chk("abort_acq_ps_en", ps_en_cnt - p0, 1);

    // en dropped during WAIT_DONE: shift completes, then idle
    k_lo = 6; k_hi = 6;
    cfg_steps = 3; cfg_avg = 2; resp_avg = 2;
    d0 = done_cnt; p0 = ps_en_cnt; w0 = wr_cnt;
    pulse_start();
    @(negedge shifting_clk);
    en = 0;
    wait_idle("abort_wait");
    en = 1;
    chk("abort_wait_phase", phase_counter, (total_done - done_base) % PP);
    chk("abort_wait_ps_en", ps_en_cnt - p0, 1);
    chk("abort_wait_no_done", done_cnt - d0, 0);
    chk("abort_wait_no_write", wr_cnt - w0, 0);

    // async reset mid-sweep, then a stray ps_done while idle
    withhold = 1; cfg_steps = 2;
    pulse_start();
    repeat (3) @(negedge shifting_clk);
    #2 S_AXI_DATA_aresetn = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_phase", phase_counter, 0);
    chk("async_rst_ps_en", bus.ps_en, 0);
    @(negedge shifting_clk);
    S_AXI_DATA_aresetn = 1; done_base = total_done;
    inject_req++;
    repeat (4) @(negedge shifting_clk);
    chk("stray_ps_done_phase", phase_counter, 0);
    chk("stray_ps_done_busy", busy, 0);
    withhold = 0;

    // three sweeps of 3 steps: phase wraps through 0 and ends at 1
    k_lo = 1; k_hi = 4;
    for (int i = 0; i < 3; i++) run_sweep(3, $urandom_range(1, 4), 0, 0);
    chk("phase_wrap_final", phase_counter, 1);

    run_sweep(0, 5, 0, 0);
    run_sweep(8, 1, 0, 0);

    ready_rand = 1; k_lo = 1; k_hi = 8;
    for (int i = 0; i < 5; i++)
      run_sweep($urandom_range(1, 5), $urandom_range(0, 12), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
